pellet_score: RTL and testbench

Pellet field and score keeper sitting directly downstream of the pacman movement block. It draws a fixed grid of pellets in VGA scan coordinates and watches the pacman fill pixel during the raster scan. Any pellet pixel that coincides with the pacman fill marks that pellet eaten and increments the score. It produces the `score` and `win` signals consumed by the movement block and the `pelletFill` consumed by the colour mux.

---
 rtl/pellet_score_if.sv | 25 ++
 rtl/pellet_score.sv | 123 ++++++++++++
 tb/tb_pellet_score.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pellet_score_if.sv
// Pellet/score keeper bus: raster scan and game control in, pellet pixel, score and status out.
interface pellet_score_if;
  logic        start;
  logic        ack;
  logic        lose;
  logic        bright;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        pacmanFill;
  logic        pelletFill;
  logic [15:0] score;
  logic        win;
  logic        eatPulse;
  logic [2:0]  state;

  modport master (
    output start, ack, lose, bright, hCount, vCount, pacmanFill,
    input  pelletFill, score, win, eatPulse, state
  );

  modport slave (
    input  start, ack, lose, bright, hCount, vCount, pacmanFill,
    output pelletFill, score, win, eatPulse, state
  );
endinterface

// File: rtl/pellet_score.sv
// Pellet field and score keeper: draws a pellet grid in scan coordinates and
// counts pellets the pacman fill passes over during play.
module pellet_score #(
  parameter int unsigned COLS      = 6,
  parameter int unsigned ROWS      = 5,
  parameter int unsigned X0        = 184,
  parameter int unsigned XSTEP     = 100,
  parameter int unsigned Y0        = 75,
  parameter int unsigned YSTEP     = 90,
  parameter int unsigned PSIZE     = 4,
  parameter int unsigned WIN_SCORE = 30
) (
  input logic           clk,
  input logic           reset,
  pellet_score_if.slave bus
);

  localparam int unsigned NP = COLS * ROWS;
  localparam int unsigned IW = (NP > 1) ? $clog2(NP) : 1;

  // Low three bits double as the one-hot debug state {LOST, WON, PLAY}.
  typedef enum logic [3:0] {
    S_INIT = 4'b0000,
    S_PLAY = 4'b0001,
    S_WON  = 4'b0010,
    S_LOST = 4'b0100,
    S_IDLE = 4'b1000
  } state_t;

  state_t         state_q, state_d;
  logic [NP-1:0]  eaten_q, eaten_d;
  logic [15:0]    score_q, score_d;
  logic           eat_pulse_q, eat_pulse_d;

  logic           in_col, in_row;
  logic [IW-1:0]  col_sel, row_sel, pidx;
  logic           pellet_fill;
  logic           hit;
  logic [15:0]    score_inc;
  logic           win_reached;

  // Locate the current pixel within the pellet grid
  always_comb begin
    in_col  = 1'b0;
    in_row  = 1'b0;
    col_sel = '0;
    row_sel = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (32'(bus.hCount) >= X0 + c * XSTEP && 32'(bus.hCount) < X0 + c * XSTEP + PSIZE) begin
        in_col  = 1'b1;
        col_sel = IW'(c);
      end
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (32'(bus.vCount) >= Y0 + r * YSTEP && 32'(bus.vCount) < Y0 + r * YSTEP + PSIZE) begin
        in_row  = 1'b1;
        row_sel = IW'(r);
      end
    end
  end

  assign pidx        = IW'(32'(row_sel) * COLS + 32'(col_sel));
  assign pellet_fill = bus.bright & in_col & in_row & ~eaten_q[pidx];
  assign hit         = pellet_fill & bus.pacmanFill & (state_q == S_PLAY);
  assign score_inc   = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
  assign win_reached = (17'(score_q) + 17'(hit)) == 17'(WIN_SCORE);

  // Next-state, field and score update
  always_comb begin
    state_d     = state_q;
    eaten_d     = eaten_q;
    score_d     = score_q;
    eat_pulse_d = 1'b0;
    unique case (state_q)
      S_INIT: begin
        eaten_d = '0;
        score_d = '0;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.start) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (hit) begin
          eaten_d[pidx] = 1'b1;
          score_d       = score_inc;
          eat_pulse_d   = 1'b1;
        end
        if (win_reached)   state_d = S_WON;
        else if (bus.lose) state_d = S_LOST;
      end
      S_WON, S_LOST: begin
        if (bus.ack) begin
          state_d = S_INIT;
          eaten_d = '0;
          score_d = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      eaten_q     <= '0;
      score_q     <= '0;
      eat_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      eaten_q     <= eaten_d;
      score_q     <= score_d;
      eat_pulse_q <= eat_pulse_d;
    end
  end

  assign bus.pelletFill = pellet_fill;
  assign bus.score      = score_q;
  assign bus.win        = state_q[1];
  assign bus.eatPulse   = eat_pulse_q;
  assign bus.state      = state_q[2:0];

endmodule

// File: tb/tb_pellet_score.sv
// Bench for pellet_score: fixed pixel table, scripted game sequences and random play
// against an arithmetic model of the pellet field.
module tb_pellet_score;

  localparam int COLS = 6, ROWS = 5, X0 = 184, XSTEP = 100, Y0 = 75, YSTEP = 90;
  localparam int PSIZE = 4, WIN_SCORE = 30, NP = COLS * ROWS;

  logic clk = 1'b0;
  logic reset;
  pellet_score_if bus ();

  pellet_score #(
    .COLS(COLS), .ROWS(ROWS), .X0(X0), .XSTEP(XSTEP), .Y0(Y0), .YSTEP(YSTEP),
    .PSIZE(PSIZE), .WIN_SCORE(WIN_SCORE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_INIT, M_IDLE, M_PLAY, M_WON, M_LOST} mstate_t;
  mstate_t m_state;
  bit      m_eaten[NP];
  int      m_score;
  bit      m_pulse;

  typedef struct {
    int h;
    int v;
    bit br;
    bit exp_fill;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int px(input int i);
    return X0 + (i % COLS) * XSTEP;
  endfunction

  function automatic int py(input int i);
    return Y0 + (i / COLS) * YSTEP;
  endfunction

  // Which pellet (if any) covers pixel (h,v), from pitch arithmetic
  function automatic bit locate(input int h, input int v, output int idx);
    int dh, dv;
    idx = 0;
    if (h < X0 || v < Y0) return 1'b0;
    dh = h - X0;
    dv = v - Y0;
    if (dh / XSTEP >= COLS || dh % XSTEP >= PSIZE) return 1'b0;
    if (dv / YSTEP >= ROWS || dv % YSTEP >= PSIZE) return 1'b0;
    idx = (dv / YSTEP) * COLS + dh / XSTEP;
    return 1'b1;
  endfunction

  function automatic bit model_fill(input int h, input int v, input bit br);
    int idx;
    bit inside_p;
    inside_p = locate(h, v, idx);
    return br && inside_p && !m_eaten[idx];
  endfunction

  function automatic logic [2:0] model_state_bits();
    case (m_state)
      M_PLAY:  return 3'b001;
      M_WON:   return 3'b010;
      M_LOST:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_clear();
    foreach (m_eaten[k]) m_eaten[k] = 1'b0;
    m_score = 0;
  endtask

  task automatic model_edge(input bit st, input bit ak, input bit ls, input bit br,
                            input int h, input int v, input bit pac);
    int  idx;
    bit  inside_p;
    bit  hit;
    inside_p = locate(h, v, idx);
    hit      = (m_state == M_PLAY) && pac && model_fill(h, v, br);
    m_pulse  = hit;
    case (m_state)
      M_INIT: begin model_clear(); m_state = M_IDLE; end
      M_IDLE: if (st) m_state = M_PLAY;
      M_PLAY: begin
        if (hit) begin
          m_eaten[idx] = 1'b1;
          if (m_score < 65535) m_score++;
        end
        if (m_score == WIN_SCORE) m_state = M_WON;
        else if (ls)              m_state = M_LOST;
      end
      default: if (ak) begin model_clear(); m_state = M_INIT; end
    endcase
  endtask

  // Drive one cycle of inputs, check the pixel output, clock, check registered outputs
  task automatic step(input bit st, input bit ak, input bit ls, input bit br,
                      input int h, input int v, input bit pac);
    bus.start      = st;
    bus.ack        = ak;
    bus.lose       = ls;
    bus.bright     = br;
    bus.hCount     = 10'(h);
    bus.vCount     = 10'(v);
    bus.pacmanFill = pac;
    #1;
    chk("pelletFill", 16'(bus.pelletFill), 16'(model_fill(h, v, br)));
    @(posedge clk);
    model_edge(st, ak, ls, br, h, v, pac);
    #1;
    chk("score", bus.score, 16'(m_score));
    chk("win", 16'(bus.win), 16'(m_state == M_WON));
    chk("eatPulse", 16'(bus.eatPulse), 16'(m_pulse));
    chk("state", 16'(bus.state), 16'(model_state_bits()));
  endtask

  task automatic eat(input int i, input bit ls);
    step(1'b0, 1'b0, ls, 1'b1, px(i) + (i % PSIZE), py(i) + ((i / 2) % PSIZE), 1'b1);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic start_step();
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic ack_step();
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int pulses;
    int h, v, ri;

    vecs[0]  = '{184, 75, 1'b1, 1'b1};
    vecs[1]  = '{187, 78, 1'b1, 1'b1};
    vecs[2]  = '{188, 75, 1'b1, 1'b0};
    vecs[3]  = '{183, 75, 1'b1, 1'b0};
    vecs[4]  = '{184, 79, 1'b1, 1'b0};
    vecs[5]  = '{284, 165, 1'b1, 1'b1};
    vecs[6]  = '{684, 435, 1'b1, 1'b1};
    vecs[7]  = '{687, 438, 1'b1, 1'b1};
    vecs[8]  = '{688, 438, 1'b1, 1'b0};
    vecs[9]  = '{184, 75, 1'b0, 1'b0};
    vecs[10] = '{200, 100, 1'b1, 1'b0};
    vecs[11] = '{0, 0, 1'b1, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0; bus.ack = 1'b0; bus.lose = 1'b0; bus.bright = 1'b0;
    bus.hCount = '0; bus.vCount = '0; bus.pacmanFill = 1'b0;
    m_state = M_INIT;
    model_clear();
    m_pulse = 1'b0;
    #12;
    chk("rst_state", 16'(bus.state), 16'd0);
    chk("rst_score", bus.score, 16'd0);
    chk("rst_win", 16'(bus.win), 16'd0);
    chk("rst_eatPulse", 16'(bus.eatPulse), 16'd0);
    reset = 1'b0;
    idle_step();

    // Fixed pixel table while idle, pacman absent
    for (int k = 0; k < 12; k++) begin
      bus.hCount = 10'(vecs[k].h);
      bus.vCount = 10'(vecs[k].v);
      bus.bright = vecs[k].br;
      #1;
      chk($sformatf("table%0d", k), 16'(bus.pelletFill), 16'(vecs[k].exp_fill));
    end

    // Hold pacman over pellet 7 for four cycles
    start_step();
    pulses = 0;
    repeat (4) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 284, 165, 1'b1);
      pulses += int'(bus.eatPulse);
    end
    chk("hold_pulses", 16'(pulses), 16'd1);
    chk("hold_score", bus.score, 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 284, 165, 1'b0);
    chk("eaten7_fill", 16'(bus.pelletFill), 16'd0);

    // Clear the rest of the field
    for (int i = 0; i < NP; i++) if (i != 7) eat(i, 1'b0);
    chk("win_after_30", 16'(bus.win), 16'd1);
    chk("score_30", bus.score, 16'd30);
    for (int i = 0; i < 3; i++) eat(i * 11, 1'b0);
    chk("score_frozen", bus.score, 16'd30);
    ack_step();
    idle_step();
    bus.hCount = 10'(px(0)); bus.vCount = 10'(py(0)); bus.bright = 1'b1;
    #1;
    chk("restored_p0", 16'(bus.pelletFill), 16'd1);

    // Final hit coinciding with lose
    start_step();
    for (int i = 0; i < NP - 1; i++) eat(i, 1'b0);
    eat(NP - 1, 1'b1);
    chk("lose_final_state", 16'(bus.state), 16'b010);
    chk("lose_final_score", bus.score, 16'd30);
    ack_step();
    idle_step();

    // Lose with score 5, then ack back to a fresh field
    start_step();
    for (int i = 0; i < 5; i++) eat(i, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("lost_state", 16'(bus.state), 16'b100);
    chk("lost_score", bus.score, 16'd5);
    step(1'b1, 1'b0, 1'b0, 1'b1, px(6), py(6), 1'b1);
    chk("lost_ignore", bus.score, 16'd5);
    ack_step();
    chk("ack_score", bus.score, 16'd0);
    idle_step();
    for (int i = 0; i < NP; i++) begin
      bus.hCount = 10'(px(i) + PSIZE - 1); bus.vCount = 10'(py(i)); bus.bright = 1'b1;
      #1;
      chk($sformatf("restored%0d", i), 16'(bus.pelletFill), 16'd1);
    end

    // Asynchronous reset mid-play
    start_step();
    for (int i = 0; i < 12; i++) eat(i, 1'b0);
    chk("pre_reset_score", bus.score, 16'd12);
    #2;
    reset = 1'b1;
    #1;
    chk("async_score", bus.score, 16'd0);
    chk("async_state", 16'(bus.state), 16'd0);
    chk("async_pulse", 16'(bus.eatPulse), 16'd0);
    chk("async_fill", 16'(bus.pelletFill), 16'd1);
    m_state = M_INIT;
    model_clear();
    m_pulse = 1'b0;
    #3;
    reset = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, px(11), py(11), 1'b1);
    chk("no_start_score", bus.score, 16'd0);
    start_step();
    eat(11, 1'b0);
    chk("after_start_score", bus.score, 16'd1);

    // Random play against the model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        ri = int'($urandom_range(NP - 1, 0));
        h  = px(ri) + int'($urandom_range(PSIZE + 1, 0)) - 1;
        v  = py(ri) + int'($urandom_range(PSIZE + 1, 0)) - 1;
      end else begin
        h = int'($urandom_range(799, 0));
        v = int'($urandom_range(524, 0));
      end
      step($urandom_range(9, 0) == 0, $urandom_range(29, 0) == 0,
           $urandom_range(149, 0) == 0, $urandom_range(9, 0) != 0,
           h, v, $urandom_range(1, 0) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
